// File: rtl/div23_swallow_ctrl_pkg.sv
// Shared types and helpers for the divide-by-2/3 pulse-swallow controller.
package div_ctrl_pkg;

    typedef enum logic {
        ST_HOLD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef enum logic {
        DIV2 = 1'b0,
        DIV3 = 1'b1
    } mod_sel_t;

    // Map a logical modulus choice onto the prescaler's physical select level.
    function automatic logic mod_level(input mod_sel_t sel, input logic div3_lvl);
        return (sel == DIV3) ? div3_lvl : ~div3_lvl;
    endfunction

    // Input-clock cycles spanned by one frame of p prescaler cycles with s divide-by-3 cycles.
    function automatic int unsigned n_total(input int unsigned p, input int unsigned s);
        return 2 * p + s;
    endfunction

endpackage

// File: rtl/div23_swallow_ctrl_if.sv
// Host/prescaler-side signal bundle of the pulse-swallow controller.
interface div23_swallow_ctrl_if #(
    parameter int unsigned W = 6
);
    logic         en;
    logic         load;
    logic [W-1:0] p_val;
    logic [W-1:0] s_val;
    logic         mod;
    logic         frame_pulse;
    logic         div_clk;
    logic         cfg_pending;
    logic         cfg_err;

    modport master (
        output en, load, p_val, s_val,
        input  mod, frame_pulse, div_clk, cfg_pending, cfg_err
    );

    modport slave (
        input  en, load, p_val, s_val,
        output mod, frame_pulse, div_clk, cfg_pending, cfg_err
    );
endinterface

// File: rtl/div23_swallow_ctrl_dn_cnt.sv
// W-bit down counter with synchronous reload, optional saturate-at-zero and zero flag.
module div_dn_cnt #(
    parameter int unsigned    W       = 6,
    parameter logic [W-1:0]   RST_VAL = '0,
    parameter bit             SAT     = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         reload,
    input  logic         dec,
    input  logic [W-1:0] reload_val,
    output logic [W-1:0] cnt_nxt,
    output logic         zero
);
    logic [W-1:0] cnt;

    always_comb begin
        cnt_nxt = cnt;
        if (reload) begin
            cnt_nxt = reload_val;
        end else if (dec) begin
            if (cnt != '0 || !SAT) begin
                cnt_nxt = cnt - W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= RST_VAL;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/div23_swallow_ctrl.sv
// Pulse-swallow controller: frames of P prescaler cycles, the first S at divide-by-3.
module div23_swallow_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int unsigned W        = 6,
    parameter int unsigned P_DEF    = 5,
    parameter int unsigned S_DEF    = 0,
    parameter bit          DIV3_LVL = 1'b1
) (
    input  logic               clk_in,
    input  logic               rst_n,
    div23_swallow_ctrl_if.slave bus
);
    state_t       state;
    logic [W-1:0] p_act, s_act;
    logic [W-1:0] p_sh, s_sh;
    logic         pend, err;
    logic         mod_r, fp_r, dclk_r;

    logic         p_zero, s_zero;
    logic [W-1:0] p_nxt, s_nxt;
    logic         boundary, apply, run_nxt, reload, load_ok;
    logic [W-1:0] p_eff, s_eff;

    always_comb begin
        boundary = (state == ST_HOLD) ? bus.en : p_zero;
        apply    = pend && boundary;
        p_eff    = apply ? p_sh : p_act;
        s_eff    = apply ? s_sh : s_act;
        // Leaving RUN is only possible on a frame's last cycle.
        run_nxt  = (state == ST_HOLD) ? bus.en : (!p_zero || bus.en);
        reload   = (state == ST_HOLD) || p_zero;
        load_ok  = (bus.p_val >= W'(2)) && (bus.s_val <= bus.p_val);
    end

    div_dn_cnt #(
        .W       (W),
        .RST_VAL (W'(P_DEF - 1)),
        .SAT     (1'b1)
    ) u_p_cnt (
        .clk        (clk_in),
        .rst_n      (rst_n),
        .reload     (reload),
        .dec        (!reload),
        .reload_val (p_eff - W'(1)),
        .cnt_nxt    (p_nxt),
        .zero       (p_zero)
    );

    div_dn_cnt #(
        .W       (W),
        .RST_VAL (W'(S_DEF)),
        .SAT     (1'b1)
    ) u_s_cnt (
        .clk        (clk_in),
        .rst_n      (rst_n),
        .reload     (reload),
        .dec        (!reload && !s_zero),
        .reload_val (s_eff),
        .cnt_nxt    (s_nxt),
        .zero       (s_zero)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state  <= ST_HOLD;
            p_act  <= W'(P_DEF);
            s_act  <= W'(S_DEF);
            p_sh   <= W'(P_DEF);
            s_sh   <= W'(S_DEF);
            pend   <= 1'b0;
            err    <= 1'b0;
            mod_r  <= mod_level(DIV2, DIV3_LVL);
            fp_r   <= 1'b0;
            dclk_r <= 1'b0;
        end else begin
            state <= run_nxt ? ST_RUN : ST_HOLD;
            if (apply) begin
                p_act <= p_sh;
                s_act <= s_sh;
            end
            // A load coinciding with an apply stays pending: the old shadow was used above.
            if (bus.load && load_ok) begin
                p_sh <= bus.p_val;
                s_sh <= bus.s_val;
                pend <= 1'b1;
                err  <= 1'b0;
            end else begin
                if (apply) begin
                    pend <= 1'b0;
                end
                if (bus.load) begin
                    err <= 1'b1;
                end
            end
            mod_r  <= mod_level((run_nxt && s_nxt != '0) ? DIV3 : DIV2, DIV3_LVL);
            fp_r   <= run_nxt && (p_nxt == '0);
            dclk_r <= run_nxt && (p_nxt >= (p_eff >> 1));
        end
    end

    assign bus.mod         = mod_r;
    assign bus.frame_pulse = fp_r;
    assign bus.div_clk     = dclk_r;
    assign bus.cfg_pending = pend;
    assign bus.cfg_err     = err;
endmodule

// File: tb/tb_div23_swallow_ctrl.sv
// Directed scenarios plus random traffic checked against a frame-position reference model.
module tb_div23_swallow_ctrl;
    import div_ctrl_pkg::*;

    localparam int unsigned W        = 6;
    localparam int unsigned P_DEF    = 5;
    localparam int unsigned S_DEF    = 0;
    localparam bit          DIV3_LVL = 1'b1;

    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;

    div23_swallow_ctrl_if #(.W(W)) bus();

    div23_swallow_ctrl #(
        .W        (W),
        .P_DEF    (P_DEF),
        .S_DEF    (S_DEF),
        .DIV3_LVL (DIV3_LVL)
    ) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model: frame position k within a P-cycle frame, plus config bookkeeping.
    bit          m_run;
    int unsigned m_k, m_p, m_s, m_psh, m_ssh;
    bit          m_pend, m_err;
    int unsigned n_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run  = 1'b0;
        m_k    = 0;
        m_p    = P_DEF;
        m_s    = S_DEF;
        m_psh  = P_DEF;
        m_ssh  = S_DEF;
        m_pend = 1'b0;
        m_err  = 1'b0;
        n_in   = 0;
    endtask

    task automatic model_edge(input bit i_en, input bit i_load, input int unsigned i_p,
                              input int unsigned i_s);
        bit last, boundary, pend_after;
        int unsigned np, ns;
        last       = m_run && (m_k == m_p - 1);
        boundary   = (!m_run && i_en) || last;
        np         = m_p;
        ns         = m_s;
        pend_after = m_pend;
        if (boundary && m_pend) begin
            np = m_psh;
            ns = m_ssh;
            pend_after = 1'b0;
        end
        if (i_load) begin
            if (i_p >= 2 && i_s <= i_p) begin
                m_psh = i_p;
                m_ssh = i_s;
                pend_after = 1'b1;
                m_err = 1'b0;
            end else begin
                m_err = 1'b1;
            end
        end
        m_pend = pend_after;
        m_p = np;
        m_s = ns;
        if (!m_run) begin
            if (i_en) begin
                m_run = 1'b1;
                m_k = 0;
            end
        end else if (last) begin
            m_k = 0;
            m_run = i_en;
        end else begin
            m_k++;
        end
    endtask

    task automatic step(input bit i_rst_n, input bit i_en, input bit i_load,
                        input int unsigned i_p, input int unsigned i_s);
        bit e_mod, e_fp, e_dclk;
        rst_n     = i_rst_n;
        bus.en    = i_en;
        bus.load  = i_load;
        bus.p_val = W'(i_p);
        bus.s_val = W'(i_s);
        @(posedge clk_in);
        #1;
        if (!i_rst_n) model_reset();
        else model_edge(i_en, i_load, i_p, i_s);
        e_mod  = (m_run && m_k < m_s) ? DIV3_LVL : ~DIV3_LVL;
        e_fp   = m_run && (m_k == m_p - 1);
        e_dclk = m_run && (m_k < (m_p + 1) / 2);
        chk("mod", 32'(bus.mod), 32'(e_mod));
        chk("frame_pulse", 32'(bus.frame_pulse), 32'(e_fp));
        chk("div_clk", 32'(bus.div_clk), 32'(e_dclk));
        chk("cfg_pending", 32'(bus.cfg_pending), 32'(m_pend));
        chk("cfg_err", 32'(bus.cfg_err), 32'(m_err));
        // Prescaler model: input-clock cycles accumulated over each frame.
        if (m_run) begin
            n_in += (bus.mod == DIV3_LVL) ? 3 : 2;
            if (e_fp) begin
                chk("n_frame", 32'(n_in), 32'(n_total(m_p, m_s)));
                n_in = 0;
            end
        end else begin
            n_in = 0;
        end
    endtask

    task automatic run(input int unsigned n, input bit i_en);
        for (int unsigned i = 0; i < n; i++) step(1'b1, i_en, 1'b0, 0, 0);
    endtask

    task automatic wait_pos(input int unsigned k);
        int unsigned budget;
        budget = 200;
        while (!(m_run && m_k == k) && budget != 0) begin
            step(1'b1, 1'b1, 1'b0, 0, 0);
            budget--;
        end
        chk("wait_pos_timeout", 32'(budget != 0), 32'd1);
    endtask

    initial begin
        bit en_r;
        int unsigned r, p, s;
        model_reset();
        step(1'b0, 1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 1'b0, 0, 0);
        run(3, 1'b0);
        run(20, 1'b1);

        step(1'b1, 1'b1, 1'b1, 5, 2);
        run(30, 1'b1);

        wait_pos(2);
        step(1'b1, 1'b1, 1'b1, 7, 3);
        run(30, 1'b1);

        step(1'b1, 1'b1, 1'b1, 4, 6);
        step(1'b1, 1'b1, 1'b1, 1, 0);
        run(10, 1'b1);
        step(1'b1, 1'b1, 1'b1, 4, 1);
        run(20, 1'b1);

        step(1'b1, 1'b1, 1'b1, 2, 2);
        run(12, 1'b1);
        step(1'b1, 1'b1, 1'b1, 63, 0);
        run(140, 1'b1);
        step(1'b1, 1'b1, 1'b1, 63, 63);
        run(140, 1'b1);

        step(1'b1, 1'b1, 1'b1, 6, 3);
        wait_pos(1);
        run(20, 1'b0);
        step(1'b1, 1'b0, 1'b1, 9, 4);
        run(4, 1'b1);
        step(1'b1, 1'b1, 1'b1, 3, 1);
        step(1'b0, 1'b1, 1'b0, 0, 0);
        run(20, 1'b1);

        // Load landing exactly on a frame boundary.
        wait_pos(4);
        step(1'b1, 1'b1, 1'b1, 8, 5);
        run(20, 1'b1);

        en_r = 1'b1;
        for (int unsigned i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 999);
            if (r < 40) en_r = ~en_r;
            p = $urandom_range(0, 63);
            s = $urandom_range(0, 63);
            if ($urandom_range(0, 3) != 0 && s > p) s = $urandom_range(0, p);
            if (r >= 990) step(1'b0, en_r, 1'b0, 0, 0);
            else step(1'b1, en_r, ($urandom_range(0, 99) < 6), p, s);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
